// File: rtl/ps2_hack_keyboard_encoder.sv
// ps2_hack_keyboard_encoder
// Receives PS/2 scan-code-set-2 frames from a keyboard and turns make/break
// sequences into the 16-bit Hack key code (0 when no key is held).

module ps2_hack_keyboard_encoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key_code,
    output logic        key_valid,
    output logic        frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        STOP   = 2'd2,
        DECODE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             clk_prev;
    logic             fall;
    logic             data_s;

    logic [3:0]       bit_cnt;
    logic [8:0]       shreg;
    logic [TMO_W-1:0] tmo_cnt;
    logic             ext_flag;
    logic             brk_flag;
    logic [7:0]       key_lo;

    logic             timeout;
    logic             frame_ok;
    logic             err_set;
    logic             do_decode;
    logic [7:0]       scan_byte;
    logic [7:0]       mapped;
    logic [7:0]       key_next;

    // Translate a scan code (with E0 extension flag) into a Hack key code; 0 = unmapped
    function automatic logic [7:0] lookup(input logic ext, input logic [7:0] sc);
        logic [7:0] c;
        c = 8'd0;
        if (ext) begin
            case (sc)
                8'h6B: c = 8'd130;
                8'h75: c = 8'd131;
                8'h74: c = 8'd132;
                8'h72: c = 8'd133;
                8'h6C: c = 8'd134;
                8'h69: c = 8'd135;
                8'h7D: c = 8'd136;
                8'h7A: c = 8'd137;
                8'h70: c = 8'd138;
                8'h71: c = 8'd139;
                default: c = 8'd0;
            endcase
        end else begin
            case (sc)
                8'h1C: c = 8'd65;
                8'h32: c = 8'd66;
                8'h21: c = 8'd67;
                8'h23: c = 8'd68;
                8'h24: c = 8'd69;
                8'h2B: c = 8'd70;
                8'h34: c = 8'd71;
                8'h33: c = 8'd72;
                8'h43: c = 8'd73;
                8'h3B: c = 8'd74;
                8'h42: c = 8'd75;
                8'h4B: c = 8'd76;
                8'h3A: c = 8'd77;
                8'h31: c = 8'd78;
                8'h44: c = 8'd79;
                8'h4D: c = 8'd80;
                8'h15: c = 8'd81;
                8'h2D: c = 8'd82;
                8'h1B: c = 8'd83;
                8'h2C: c = 8'd84;
                8'h3C: c = 8'd85;
                8'h2A: c = 8'd86;
                8'h1D: c = 8'd87;
                8'h22: c = 8'd88;
                8'h35: c = 8'd89;
                8'h1A: c = 8'd90;
                8'h45: c = 8'd48;
                8'h16: c = 8'd49;
                8'h1E: c = 8'd50;
                8'h26: c = 8'd51;
                8'h25: c = 8'd52;
                8'h2E: c = 8'd53;
                8'h36: c = 8'd54;
                8'h3D: c = 8'd55;
                8'h3E: c = 8'd56;
                8'h46: c = 8'd57;
                8'h29: c = 8'd32;
                8'h5A: c = 8'd128;
                8'h66: c = 8'd129;
                8'h76: c = 8'd140;
                8'h05: c = 8'd141;
                8'h06: c = 8'd142;
                8'h04: c = 8'd143;
                8'h0C: c = 8'd144;
                8'h03: c = 8'd145;
                8'h0B: c = 8'd146;
                8'h83: c = 8'd147;
                8'h0A: c = 8'd148;
                8'h01: c = 8'd149;
                8'h09: c = 8'd150;
                8'h78: c = 8'd151;
                8'h07: c = 8'd152;
                default: c = 8'd0;
            endcase
        end
        return c;
    endfunction

    assign fall      = clk_prev & ~clk_sync[1];
    assign data_s    = data_sync[1];
    assign scan_byte = shreg[7:0];
    assign key_code  = {8'h00, key_lo};

    // Bring the asynchronous PS/2 lines into the clk domain and keep the previous clock level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start bit, nine shifted bits, stop bit, one decode cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fall && !data_s) state_next = SHIFT;
            end
            SHIFT: begin
                if (timeout) state_next = IDLE;
                else if (fall && bit_cnt == 4'd9) state_next = STOP;
            end
            STOP: begin
                if (timeout) state_next = IDLE;
                else if (fall) state_next = frame_ok ? DECODE : IDLE;
            end
            DECODE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/control decode: error detection and next held-key value
    always_comb begin
        timeout   = ((state == SHIFT) || (state == STOP)) && !fall && (tmo_cnt == TMO_LAST);
        frame_ok  = data_s && (^shreg);
        err_set   = ((state == IDLE) && fall && data_s)
                  || timeout
                  || ((state == STOP) && fall && !frame_ok);
        do_decode = (state == DECODE);
        mapped    = lookup(ext_flag, scan_byte);
        key_next  = key_lo;
        if (do_decode && scan_byte != 8'hE0 && scan_byte != 8'hF0 && mapped != 8'd0) begin
            if (brk_flag) begin
                if (mapped == key_lo) key_next = 8'd0;
            end else begin
                key_next = mapped;
            end
        end
    end

    // Bit counter, shift register and inactivity timer for the frame in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 4'd0;
            shreg   <= 9'd0;
            tmo_cnt <= '0;
        end else begin
            if ((state == SHIFT || state == STOP) && !fall && !timeout) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            if (timeout) begin
                bit_cnt <= 4'd0;
            end else if (fall) begin
                case (state)
                    IDLE: if (!data_s) bit_cnt <= 4'd1;
                    SHIFT: begin
                        shreg   <= {data_s, shreg[8:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    STOP: bit_cnt <= 4'd0;
                    default: bit_cnt <= bit_cnt;
                endcase
            end
        end
    end

    // Prefix flags, held key and the one-cycle strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            key_lo    <= 8'd0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_set;
            key_valid <= (key_next != key_lo);
            key_lo    <= key_next;
            if (timeout) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (do_decode) begin
                if (scan_byte == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (scan_byte == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_hack_keyboard_encoder.sv
// tb_ps2_hack_keyboard_encoder
// Directed PS/2 frames against hand-computed Hack key codes.

module tb_ps2_hack_keyboard_encoder;

    localparam int TMO = 300;

    logic        clk;
    logic        rst_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] key_code;
    logic        key_valid;
    logic        frame_err;

    int checks;
    int passes;
    int valid_cnt;
    int err_cnt;
    int v0;
    int e0;

    ps2_hack_keyboard_encoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_code  (key_code),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    // Free-running 100 MHz system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count strobe cycles, sampled away from the active edge
    always @(negedge clk) begin
        if (key_valid) valid_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic sendBit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Send the first n bits of a frame carrying byte b (parity optionally inverted)
    task automatic applyStimulus(input logic [7:0] b, input logic bad_parity, input int n);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
        for (int i = 0; i < n; i++) sendBit(f[i]);
        repeat (10) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(b, 1'b0, 11);
    endtask

    initial begin
        logic [10:0] f;
        checks    = 0;
        passes    = 0;
        valid_cnt = 0;
        err_cnt   = 0;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset key_code", key_code, 16'h0000);
        checkOutput("reset key_valid", {15'd0, key_valid}, 16'h0000);
        checkOutput("reset frame_err", {15'd0, frame_err}, 16'h0000);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Make A (1C) with a cycle-accurate look at the stop bit
        v0 = valid_cnt;
        f = {1'b1, 1'b0, 8'h1C, 1'b0};
        for (int i = 0; i < 10; i++) sendBit(f[i]);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("A not yet", key_code, 16'h0000);
        @(negedge clk);
        checkOutput("A latency", key_code, 16'h0041);
        checkOutput("A valid high", {15'd0, key_valid}, 16'h0001);
        @(negedge clk);
        checkOutput("A valid low", {15'd0, key_valid}, 16'h0000);
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("A valid count", 16'(valid_cnt - v0), 16'd1);

        v0 = valid_cnt;
        sendByte(8'hF0);
        sendByte(8'h1C);
        checkOutput("A break", key_code, 16'h0000);
        checkOutput("A break valid", 16'(valid_cnt - v0), 16'd1);

        // Extended up arrow
        sendByte(8'hE0);
        sendByte(8'h75);
        checkOutput("up make", key_code, 16'd131);
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h75);
        checkOutput("up break", key_code, 16'd0);
        v0 = valid_cnt;
        sendByte(8'hF0);
        sendByte(8'h75);
        checkOutput("non-ext 75", key_code, 16'd0);
        checkOutput("non-ext 75 valid", 16'(valid_cnt - v0), 16'd0);

        // Overlapping keys
        sendByte(8'h1C);
        sendByte(8'h32);
        checkOutput("B overrides", key_code, 16'h0042);
        v0 = valid_cnt;
        sendByte(8'h32);
        checkOutput("typematic valid", 16'(valid_cnt - v0), 16'd0);
        sendByte(8'hF0);
        sendByte(8'h1C);
        checkOutput("break other key", key_code, 16'h0042);
        sendByte(8'hF0);
        sendByte(8'h32);
        checkOutput("B break", key_code, 16'h0000);

        // Parity error then a good space
        e0 = err_cnt;
        applyStimulus(8'h1C, 1'b1, 11);
        checkOutput("parity err", 16'(err_cnt - e0), 16'd1);
        checkOutput("parity key", key_code, 16'h0000);
        sendByte(8'h29);
        checkOutput("space", key_code, 16'd32);

        // Timeout on a partial frame, then enter
        e0 = err_cnt;
        applyStimulus(8'h5A, 1'b0, 5);
        repeat (TMO + 20) @(negedge clk);
        checkOutput("timeout err", 16'(err_cnt - e0), 16'd1);
        e0 = err_cnt;
        sendByte(8'h5A);
        checkOutput("enter", key_code, 16'd128);
        checkOutput("enter no err", 16'(err_cnt - e0), 16'd0);

        // Start bit of 1 is an error; F1 afterwards
        e0 = err_cnt;
        sendBit(1'b1);
        repeat (10) @(negedge clk);
        checkOutput("bad start err", 16'(err_cnt - e0), 16'd1);
        sendByte(8'h05);
        checkOutput("F1", key_code, 16'd141);

        // Reset mid-frame while A is held
        sendByte(8'h1C);
        checkOutput("A again", key_code, 16'd65);
        applyStimulus(8'h2D, 1'b0, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset", key_code, 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        sendByte(8'h16);
        checkOutput("digit 1", key_code, 16'd49);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
